ds_hazard_scoreboard: RTL

//  Issue controller for the decode stage. Keeps a per-GPR count of in-flight writes, issued at
//  ds->es and retired at the WB regfile write port. Drives decode's ds_ready_go so that a RAW

---
 rtl/ds_hazard_scoreboard.sv | 115 +++++++++++
 1 files changed

// File: rtl/ds_hazard_scoreboard.sv
// rtl/ds_hazard_scoreboard.sv - decode-stage issue controller with per-GPR pending-write scoreboard
module ds_hazard_scoreboard #(
  parameter int NREG   = 32,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ds_valid,
  input  logic [4:0]        ds_rs,
  input  logic              ds_rs_used,
  input  logic [4:0]        ds_rt,
  input  logic              ds_rt_used,
  input  logic [4:0]        ds_dest,
  input  logic              ds_gr_we,
  input  logic              ds_serial,
  input  logic              ds_issue,
  input  logic              ws_we,
  input  logic [4:0]        ws_waddr,
  input  logic              flush,
  output logic              ds_ready_go,
  output logic              sb_empty,
  output logic [1:0]        hz_state,
  output logic [PERF_W-1:0] stall_cycles,
  output logic              sb_err
);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_STALL_RAW = 2'd1,
    S_DRAIN     = 2'd2,
    S_FLUSH_BUB = 2'd3
  } hz_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  r_cnt [NREG];
  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic [PERF_W-1:0] r_stall;
  logic              r_err;

  logic [NREG-1:0]   w_busy;
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;
  logic              w_raw;
  logic              w_sat;
  logic              w_drain;
  logic              w_empty;
  logic              w_underflow;
  logic              w_ready_go;

  // r0 is never tracked, so its busy/inc/dec bits are tied low.
  always_comb begin
    w_busy = '0;
    w_inc  = '0;
    w_dec  = '0;
    for (int i = 1; i < NREG; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
      w_inc[i]  = ds_issue & ds_gr_we & (ds_dest == 5'(i));
      w_dec[i]  = ws_we & (ws_waddr == 5'(i));
    end
  end

  assign w_empty     = ~|w_busy;
  assign w_raw       = ds_valid & ((ds_rs_used & w_busy[ds_rs]) | (ds_rt_used & w_busy[ds_rt]));
  assign w_sat       = ds_valid & ds_gr_we & (ds_dest != 5'd0) & (r_cnt[ds_dest] == CNT_MAX);
  assign w_drain     = ds_valid & ds_serial & ~w_empty;
  assign w_underflow = |(w_dec & ~w_inc & ~w_busy);
  assign w_ready_go  = ~(w_raw | w_sat | w_drain) & (r_state != S_FLUSH_BUB);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset || flush) begin
        r_cnt[i] <= '0;
      end else if (w_inc[i] && !w_dec[i] && r_cnt[i] != CNT_MAX) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end else if (w_dec[i] && !w_inc[i] && r_cnt[i] != '0) begin
        r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err   <= 1'b0;
      r_stall <= '0;
    end else begin
      if (!flush && w_underflow) r_err <= 1'b1;
      if (ds_valid && !w_ready_go && r_stall != '1) r_stall <= r_stall + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // Records the cause of the current hold one cycle late; only FLUSH_BUB gates issue.
  always_comb begin
    w_state_nxt = S_RUN;
    if (flush)                      w_state_nxt = S_FLUSH_BUB;
    else if (r_state == S_FLUSH_BUB) w_state_nxt = S_RUN;
    else if (w_drain)               w_state_nxt = S_DRAIN;
    else if (w_raw || w_sat)        w_state_nxt = S_STALL_RAW;
    else                            w_state_nxt = S_RUN;
  end

  assign ds_ready_go  = w_ready_go;
  assign sb_empty     = w_empty;
  assign hz_state     = r_state;
  assign stall_cycles = r_stall;
  assign sb_err       = r_err;

endmodule
